interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
//
// PURPOSE
//  Round-robin interrupt controller feeding the core's INT_i/mcause_i inputs.
//  Captures rising edges on peripheral request lines into a sticky pending register
//  and masks them with the core's mie_o. A scan counter then selects one line,
//  raises INT_o to the core and holds it until the core's INT_RST_o completes
//  the handler. It then returns a one-cycle acknowledge pulse to the serviced peripheral.
//
// PARAMETERS
//  N_IRQ  16  number of request lines, legal 1..32; CW = (N_IRQ>1) ? $clog2(N_IRQ) : 1
//
// PORTS
//  clk_i      in   1      clock; one clock domain
//  rst_i      in   1      reset; synchronous, active-high
//  int_req_i  in   N_IRQ  peripheral request lines, rising edge = new event
//  mie_i      in   32     interrupt enable mask from core CSR; bits [N_IRQ-1:0] used
//  INT_RST_i  in   1      handler-complete strobe from core (core INT_RST_o)
//  INT_o      out  1      interrupt request to core (core INT_i)
//  mcause_o   out  32     cause of the current interrupt (core mcause_i)
//  int_fin_o  out  N_IRQ  one-hot, one-cycle acknowledge to the serviced peripheral
//
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  - Reset (rst_i=1 at edge): state=IDLE, cnt=0, pending=0, req_q=0, irq_id=0,
//    INT_o=0, mcause_o=0, int_fin_o=0. Reset mid-operation drops everything; no fin pulse.
//  - All outputs are registered.
//  - Edge capture: req_q <= int_req_i each cycle; rise = int_req_i & ~req_q.
//    pending <= (pending & ~clr) | rise. Same-bit rise and clr in one cycle: set wins.
//  - masked = pending & mie_i[N_IRQ-1:0], evaluated combinationally every cycle.
//  - FSM:
//    IDLE: if |masked -> SCAN (cnt unchanged) else stay.
//    SCAN: if masked==0 -> IDLE.
//          elsif masked[cnt] -> BUSY; irq_id<=cnt; mcause_o<={1'b1,31'(cnt)}.
//          else cnt <= (cnt==N_IRQ-1) ? 0 : cnt+1.
//    BUSY: INT_o=1; mcause_o stable.
//          On INT_RST_i -> IDLE; clr=onehot(irq_id) applied at this edge;
//          int_fin_o<=onehot(irq_id) for exactly the next cycle;
//          cnt <= (irq_id==N_IRQ-1) ? 0 : irq_id+1 (round-robin fairness).
//  - INT_o = (state==BUSY), registered.
//  - mcause_o is updated only on SCAN->BUSY and holds its value otherwise.
//  - INT_RST_i outside BUSY is ignored.
//  - Changes to mie_i while BUSY do not cancel the held interrupt.
//    Clearing a mie_i bit during SCAN masks that line from the next comparison.
//  - A line held high through completion does not re-pend; a new rising edge is required.
//  - Latency: the edge sampling a rise is E0. With d=(k-cnt) mod N_IRQ,
//    INT_o is 1 after edge E(3+d). Worst case is N_IRQ+2 edges.
//  - One interrupt in flight at a time; no nesting.
//
// TESTING
//  1 Reset: drive rst_i=1 for 2 cycles with random inputs
//    -> INT_o=0, mcause_o=0, int_fin_o=0, no activity afterwards with int_req_i=0.
//  2 Single line: N_IRQ=16, cnt=0, mie_i=32'h8, int_req_i[3] rises
//    -> INT_o=1 after edge E6, mcause_o=32'h8000_0003.
//    Then INT_RST_i pulse -> INT_o=0 next cycle, int_fin_o=16'h0008 for 1 cycle.
//  3 Masking: mie_i=0, int_req_i[2] rises -> INT_o stays 0 for 50 cycles.
//    Then mie_i=32'h4 -> INT_o=1 and mcause_o=32'h8000_0002 without a new edge.
//  4 Round-robin: lines 1 and 5 rise together, cnt=0 -> line 1 served first.
//    Line 1 re-rises during its handler; after INT_RST_i, line 5 is served next
//    (mcause_o=32'h8000_0005), then line 1.
//  5 Level hold and stray strobe: int_req_i[7] held high through completion
//    -> exactly one interrupt, one int_fin_o pulse.
//    INT_RST_i asserted in IDLE -> no state or output change.
//  6 Reset mid-BUSY: rst_i=1 while INT_o=1 -> INT_o=0 and pending=0 next cycle,
//    int_fin_o never pulses, no interrupt after release.

Source files
------------

// File: rtl/interrupt_controller.sv
// Round-robin interrupt controller: rising edges on request lines become sticky pending bits,
// masked by mie, scanned one line per cycle and held on INT_o until the core's completion strobe.
module interrupt_controller #(
   parameter int unsigned N_IRQ = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_IRQ-1:0] int_req_i,
   input  logic [31:0]      mie_i,
   input  logic             INT_RST_i,
   output logic             INT_o,
   output logic [31:0]      mcause_o,
   output logic [N_IRQ-1:0] int_fin_o
);

   localparam int unsigned   CW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_IRQ - 1);

   typedef enum logic [1:0] {IDLE, SCAN, BUSY} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    irq_id;
   logic [N_IRQ-1:0] req_q;
   logic [N_IRQ-1:0] pending;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] masked;
   logic [N_IRQ-1:0] sel_onehot;
   logic [N_IRQ-1:0] clr;
   logic             done;
   logic [31:0]      mie_unused;

   // mie bits above N_IRQ carry no lines
   assign mie_unused = mie_i;

   always_comb begin
      rise       = int_req_i & ~req_q;
      masked     = pending & mie_i[N_IRQ-1:0];
      sel_onehot = N_IRQ'(1) << irq_id;
      done       = (state == BUSY) && INT_RST_i;
      clr        = done ? sel_onehot : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         irq_id    <= '0;
         req_q     <= '0;
         pending   <= '0;
         INT_o     <= 1'b0;
         mcause_o  <= '0;
         int_fin_o <= '0;
      end else begin
         req_q     <= int_req_i;
         // a rise coinciding with the clear of the same line survives
         pending   <= (pending & ~clr) | rise;
         INT_o     <= (state == BUSY) && !INT_RST_i;
         int_fin_o <= '0;
         case (state)
            IDLE: begin
               if (|masked) state <= SCAN;
            end
            SCAN: begin
               if (masked == '0) begin
                  state <= IDLE;
               end else if (masked[cnt]) begin
                  state    <= BUSY;
                  irq_id   <= cnt;
                  mcause_o <= {1'b1, 31'(cnt)};
               end else begin
                  cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
               end
            end
            BUSY: begin
               if (INT_RST_i) begin
                  state     <= IDLE;
                  int_fin_o <= sel_onehot;
                  cnt       <= (irq_id == LAST) ? '0 : irq_id + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus randomized traffic
// compared every cycle against a line-by-line behavioural model.
module tb_interrupt_controller;

   localparam int unsigned N = 16;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [N-1:0]  int_req_i;
   logic [31:0]   mie_i;
   logic          INT_RST_i;
   logic          INT_o;
   logic [31:0]   mcause_o;
   logic [N-1:0]  int_fin_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   interrupt_controller #(.N_IRQ(N)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .int_req_i (int_req_i),
      .mie_i     (mie_i),
      .INT_RST_i (INT_RST_i),
      .INT_o     (INT_o),
      .mcause_o  (mcause_o),
      .int_fin_o (int_fin_o)
   );

   always #5 clk = ~clk;

   // Behavioural model: per-line flags, a rotating pointer and a mode
   // (0 quiet, 1 hunting for a line, 2 serving a line).
   bit           pend [N];
   bit           seen [N];
   int           ptr;
   int           owner;
   int           mode;
   bit           finishing;
   bit           live;
   bit           exp_int;
   logic [31:0]  exp_cause;
   logic [N-1:0] exp_fin;

   function automatic bit any_enabled();
      for (int i = 0; i < N; i++)
         if (pend[i] && mie_i[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (rst_i) begin
         for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            seen[i] = 1'b0;
         end
         ptr = 0; owner = 0; mode = 0;
         exp_int = 1'b0; exp_cause = 32'h0; exp_fin = '0;
      end else begin
         finishing = (mode == 2) && INT_RST_i;
         live      = any_enabled();
         exp_int   = (mode == 2) && !INT_RST_i;
         exp_fin   = '0;
         if (mode == 0) begin
            if (live) mode = 1;
         end else if (mode == 1) begin
            if (!live) mode = 0;
            else if (pend[ptr] && mie_i[ptr]) begin
               mode = 2;
               owner = ptr;
               exp_cause = 32'h8000_0000 + ptr;
            end else ptr = (ptr + 1) % N;
         end else if (finishing) begin
            mode = 0;
            exp_fin[owner] = 1'b1;
            ptr = (owner + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (finishing && i == owner) pend[i] = 1'b0;
            if (int_req_i[i] && !seen[i]) pend[i] = 1'b1;
            seen[i] = int_req_i[i];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      check("model_int", {31'b0, INT_o}, {31'b0, exp_int});
      check("model_mcause", mcause_o, exp_cause);
      check("model_fin", {16'b0, int_fin_o}, {16'b0, exp_fin});
   endtask

   task automatic do_reset();
      rst_i = 1'b1; int_req_i = '0; INT_RST_i = 1'b0;
      cyc(); cyc();
      rst_i = 1'b0;
   endtask

   task automatic strobe();
      INT_RST_i = 1'b1;
      cyc();
      INT_RST_i = 1'b0;
   endtask

   task automatic wait_int(input string tag, input int max);
      int k = 0;
      while (INT_o !== 1'b1 && k < max) begin
         cyc();
         k++;
      end
      check(tag, {31'b0, INT_o}, 32'd1);
   endtask

   task automatic quiet_window(input string tag, input int len);
      int hits = 0;
      for (int i = 0; i < len; i++) begin
         cyc();
         if (INT_o !== 1'b0 || int_fin_o !== '0) hits++;
      end
      check(tag, hits, 0);
   endtask

   initial begin
      // 1: reset with random inputs
      rst_i = 1'b1; INT_RST_i = 1'($urandom); int_req_i = N'($urandom); mie_i = $urandom;
      cyc();
      INT_RST_i = 1'($urandom); int_req_i = N'($urandom); mie_i = $urandom;
      cyc();
      check("rst_int", {31'b0, INT_o}, 32'd0);
      check("rst_mcause", mcause_o, 32'd0);
      check("rst_fin", {16'b0, int_fin_o}, 32'd0);
      rst_i = 1'b0; int_req_i = '0; INT_RST_i = 1'b0;
      quiet_window("rst_quiet", 20);

      // 2: single line, latency from cnt=0
      do_reset();
      mie_i = 32'h8;
      int_req_i = 16'h0008;
      cyc();
      begin
         int early = 0;
         for (int i = 1; i <= 5; i++) begin
            cyc();
            if (INT_o !== 1'b0) early++;
         end
         check("t2_early", early, 0);
      end
      cyc();
      check("t2_int_e6", {31'b0, INT_o}, 32'd1);
      check("t2_mcause", mcause_o, 32'h8000_0003);
      strobe();
      check("t2_int_drop", {31'b0, INT_o}, 32'd0);
      check("t2_fin", {16'b0, int_fin_o}, 32'h0008);
      int_req_i = '0;
      cyc();
      check("t2_fin_once", {16'b0, int_fin_o}, 32'd0);

      // 3: masked line waits, then fires without a new edge
      do_reset();
      mie_i = 32'h0;
      int_req_i = 16'h0004;
      quiet_window("t3_masked", 50);
      mie_i = 32'h4;
      wait_int("t3_unmask", 20);
      check("t3_mcause", mcause_o, 32'h8000_0002);
      strobe();
      check("t3_fin", {16'b0, int_fin_o}, 32'h0004);
      int_req_i = '0;

      // 4: round-robin between lines 1 and 5
      do_reset();
      mie_i = 32'hFFFF;
      int_req_i = 16'h0022;
      wait_int("t4_first", 20);
      check("t4_mcause1", mcause_o, 32'h8000_0001);
      int_req_i = 16'h0020;
      cyc(); cyc(); cyc();
      int_req_i = 16'h0022;
      strobe();
      check("t4_fin1", {16'b0, int_fin_o}, 32'h0002);
      wait_int("t4_second", 30);
      check("t4_mcause5", mcause_o, 32'h8000_0005);
      strobe();
      check("t4_fin5", {16'b0, int_fin_o}, 32'h0020);
      wait_int("t4_third", 30);
      check("t4_mcause1b", mcause_o, 32'h8000_0001);
      strobe();
      check("t4_fin1b", {16'b0, int_fin_o}, 32'h0002);
      quiet_window("t4_drained", 20);
      int_req_i = '0;

      // 5: level hold gives one interrupt; stray strobe in idle is ignored
      do_reset();
      mie_i = 32'hFFFF;
      int_req_i = 16'h0080;
      wait_int("t5_int", 20);
      check("t5_mcause", mcause_o, 32'h8000_0007);
      strobe();
      check("t5_fin", {16'b0, int_fin_o}, 32'h0080);
      quiet_window("t5_no_repend", 30);
      strobe();
      check("t5_stray_int", {31'b0, INT_o}, 32'd0);
      check("t5_stray_fin", {16'b0, int_fin_o}, 32'd0);
      check("t5_stray_mcause", mcause_o, 32'h8000_0007);
      int_req_i = '0;

      // 6: reset while busy drops everything
      do_reset();
      mie_i = 32'hFFFF;
      int_req_i = 16'h0200;
      wait_int("t6_int", 20);
      rst_i = 1'b1; int_req_i = '0;
      cyc();
      rst_i = 1'b0;
      check("t6_int", {31'b0, INT_o}, 32'd0);
      check("t6_pending", {16'b0, dut.pending}, 32'd0);
      check("t6_fin", {16'b0, int_fin_o}, 32'd0);
      quiet_window("t6_after", 30);

      // randomized traffic against the model
      do_reset();
      mie_i = 32'hFFFF;
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 11) == 0) int_req_i[b] = ~int_req_i[b];
         if ($urandom_range(0, 99) == 0) mie_i = $urandom | $urandom;
         if (mode == 2) INT_RST_i = ($urandom_range(0, 3) == 0);
         else           INT_RST_i = ($urandom_range(0, 49) == 0);
         rst_i = ($urandom_range(0, 599) == 0);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
